// File: rtl/dcache_wt_if.sv
// Memory-side bus of the write-through data cache: a valid/ready request channel
// plus a single-cycle response-valid refill channel.
interface dcache_wt_if #(
    parameter int MEM_ADDR_BITS = 28
);
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_rw;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic [127:0]             mem_req_data;
    logic [15:0]              mem_req_mask;
    logic                     mem_resp_valid;
    logic [127:0]             mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 128-bit lines.
// Read hits return data the next cycle; misses refill a whole line, then replay as a hit.
module dcache_wt #(
    parameter int LINES         = 64,
    parameter int MEM_ADDR_BITS = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    dcache_wt_if.master mem
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]       word;
    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;
    logic             is_write;
    logic             hit;
    logic [31:0]      hit_word;
    logic             refill_en;
    logic             wr_merge_en;
    logic             read_hit_en;
    logic             unused_addr_lsbs;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];

    assign word     = dcache_addr[3:2];
    assign idx      = dcache_addr[4 +: IDX];
    assign tag      = dcache_addr[31 -: TAG_W];
    assign is_write = |dcache_we;
    assign unused_addr_lsbs = ^dcache_addr[1:0];

    assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
    assign hit_word = data_mem[idx][{word, 5'b00000} +: 32];

    assign refill_en   = (state == RD_WAIT) && mem.mem_resp_valid;
    assign wr_merge_en = (state == WR_REQ) && mem.mem_req_ready && hit;
    assign read_hit_en = (state == IDLE) && dcache_re && !is_write && hit;

    // The core holds its request while stalled, so these can follow the inputs directly.
    assign mem.mem_req_addr = MEM_ADDR_BITS'(dcache_addr[31:4]);
    assign mem.mem_req_data = {4{dcache_din}};
    assign mem.mem_req_mask = 16'(dcache_we) << {word, 2'b00};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
        next_state        = state;
        stall             = 1'b0;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_rw    = 1'b0;
        case (state)
            IDLE: begin
                if (is_write) begin
                    stall      = 1'b1;
                    next_state = WR_REQ;
                end else if (dcache_re && !hit) begin
                    stall      = 1'b1;
                    next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                stall             = 1'b1;
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) next_state = RD_WAIT;
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (mem.mem_resp_valid) next_state = IDLE;
            end
            WR_REQ: begin
                stall             = 1'b1;
                mem.mem_req_valid = 1'b1;
                mem.mem_req_rw    = 1'b1;
                if (mem.mem_req_ready) next_state = WR_DONE;
            end
            WR_DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state       <= IDLE;
            valid_q     <= '0;
            dcache_dout <= '0;
        end else begin
            state <= next_state;
            if (refill_en) valid_q[idx] <= 1'b1;
            if (read_hit_en) dcache_dout <= hit_word;
        end
    end

    // NOTE: tag/data arrays carry no reset; cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (reset && refill_en) begin
            data_mem[idx] <= mem.mem_resp_data;
            tag_mem[idx]  <= tag;
        end
        if (reset && wr_merge_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dcache_we[b]) data_mem[idx][{word, b[1:0], 3'b000} +: 8] <= dcache_din[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: a line-level cache/memory model plus a bus responder
// compared against the DUT every cycle, with hand-computed literals from the directed scenarios.
module tb_dcache_wt;
    localparam int LINES = 64;
    localparam int MAB   = 28;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        stall;

    dcache_wt_if #(.MEM_ADDR_BITS(MAB)) mem_bus ();

    dcache_wt #(.LINES(LINES), .MEM_ADDR_BITS(MAB)) dut (
        .clk         (clk),
        .reset       (reset),
        .dcache_addr (addr),
        .dcache_re   (re),
        .dcache_we   (we),
        .dcache_din  (din),
        .dcache_dout (dout),
        .stall       (stall),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: cache contents by set, and a sparse backing memory by line number.
    bit           m_valid [LINES];
    int           m_tag   [LINES];
    logic [127:0] m_data  [LINES];
    logic [127:0] backing [int];

    function automatic logic [127:0] default_line(input int l);
        logic [127:0] r;
        if (l == 16) return {32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF};
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'h1000_0000 + 32'(l * 16 + w * 4);
        return r;
    endfunction

    function automatic logic [127:0] mem_line(input int l);
        if (backing.exists(l)) return backing[l];
        return default_line(l);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int l;
        l = int'(a >> 4);
        return m_valid[l % LINES] && (m_tag[l % LINES] == l / LINES);
    endfunction

    // Responder / scoreboard state
    int           ready_delay = 0;
    int           resp_lat    = 2;
    int           wait_cnt    = 0;
    int           resp_cd     = 0;
    int           resp_line   = 0;
    int           hs_count    = 0;
    logic [27:0]  last_addr   = '0;
    logic         last_rw     = 1'b0;
    logic [15:0]  last_mask   = '0;
    bit           pending     = 1'b0;
    logic [31:0]  pending_val = '0;

    always @(negedge clk) begin
        int           l;
        int           s;
        int           w;
        logic [127:0] exp_data;
        logic [15:0]  exp_mask;

        mem_bus.mem_resp_valid = 1'b0;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                mem_bus.mem_resp_valid = 1'b1;
                mem_bus.mem_resp_data  = mem_line(resp_line);
            end
        end

        if (!reset) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            mem_bus.mem_req_ready = 1'b0;
            wait_cnt = 0;
            pending  = 1'b0;
        end else begin
            if (pending) check("dout", dout, pending_val);
            pending = 1'b0;

            l = int'(addr >> 4);
            s = l % LINES;
            w = int'(addr[3:2]);

            if (mem_bus.mem_req_valid) begin
                check("req_addr", mem_bus.mem_req_addr, addr[31:4]);
                check("req_rw", mem_bus.mem_req_rw, (we != 4'b0000));
                check("req_stall", stall, 1'b1);
                if (we != 4'b0000) begin
                    for (int k = 0; k < 4; k++) exp_data[k*32 +: 32] = din;
                    for (int b = 0; b < 16; b++) exp_mask[b] = (b / 4 == w) && we[b % 4];
                    check("req_data", mem_bus.mem_req_data, exp_data);
                    check("req_mask", mem_bus.mem_req_mask, exp_mask);
                end
                mem_bus.mem_req_ready = (wait_cnt >= ready_delay);
                if (mem_bus.mem_req_ready) begin
                    wait_cnt = 0;
                    hs_count++;
                    last_addr = mem_bus.mem_req_addr;
                    last_rw   = mem_bus.mem_req_rw;
                    last_mask = mem_bus.mem_req_mask;
                    if (mem_bus.mem_req_rw) begin
                        // Write-through: memory always updated, cache only if the line is present.
                        exp_data = mem_line(l);
                        for (int b = 0; b < 4; b++)
                            if (we[b]) exp_data[w*32 + b*8 +: 8] = din[b*8 +: 8];
                        backing[l] = exp_data;
                        if (model_hit(addr)) m_data[s] = exp_data;
                    end else begin
                        resp_line = l;
                        resp_cd   = resp_lat;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_bus.mem_req_ready = 1'b0;
                wait_cnt = 0;
            end

            if (re && we == 4'b0000 && !stall) begin
                if (!model_hit(addr)) begin
                    m_valid[s] = 1'b1;
                    m_tag[s]   = l / LINES;
                    m_data[s]  = mem_line(l);
                end
                pending_val = m_data[s][w*32 +: 32];
                pending     = 1'b1;
            end
        end
    end

    task automatic rd(input logic [31:0] a, output int n);
        bit exp_hit;
        int hs0;
        @(posedge clk);
        #1;
        addr = a; re = 1'b1; we = 4'b0000;
        exp_hit = model_hit(a);
        hs0 = hs_count;
        @(negedge clk);
        check("rd_stall_first", stall, !exp_hit);
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall) check("rd_timeout", stall, 1'b0);
        check("rd_mem_reqs", hs_count - hs0, exp_hit ? 0 : 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input int delay, output int n);
        int hs0;
        @(posedge clk);
        #1;
        addr = a; re = 1'b0; we = be; din = d;
        ready_delay = delay;
        hs0 = hs_count;
        @(negedge clk);
        check("wr_stall_first", stall, 1'b1);
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall) check("wr_timeout", stall, 1'b0);
        check("wr_mem_reqs", hs_count - hs0, 1);
        ready_delay = 0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        re = 1'b0; we = 4'b0000;
        @(negedge clk);
        check("idle_stall", stall, 1'b0);
        check("idle_req", mem_bus.mem_req_valid, 1'b0);
    endtask

    initial begin
        int n;
        int hs0;
        reset = 1'b0;
        addr  = '0;
        re    = 1'b0;
        we    = 4'b0000;
        din   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_req", mem_bus.mem_req_valid, 1'b0);
        check("rst_dout", dout, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Cold read miss, memory ready at once, response two cycles after the request.
        rd(32'h0000_0100, n);
        check("cold_stall_cycles", n, 4);
        check("cold_req_addr", last_addr, 28'h10);
        check("cold_req_rw", last_rw, 1'b0);
        idle();
        check("cold_dout", dout, 32'hDEAD_BEEF);

        // Hits right after the fill, then back-to-back hits.
        rd(32'h0000_0104, n);
        check("hit_stall_cycles", n, 0);
        idle();
        check("hit_dout_w1", dout, 32'hCAFE_F00D);
        rd(32'h0000_0100, n);
        rd(32'h0000_0104, n);
        rd(32'h0000_0108, n);
        idle();
        check("b2b_dout_w2", dout, 32'h1234_5678);

        // Store hit with ready held low for three cycles.
        wr(32'h0000_0101, 4'b0010, 32'h0000_AB00, 3, n);
        check("st_stall_cycles", n, 5);
        check("st_mask", last_mask, 16'h0002);
        check("st_rw", last_rw, 1'b1);
        idle();
        rd(32'h0000_0100, n);
        check("st_read_hit", n, 0);
        idle();
        check("st_merged", dout, 32'hDEAD_ABEF);

        // Write miss: memory written, cache not allocated.
        wr(32'h0000_200C, 4'b1111, 32'h5566_7788, 0, n);
        check("wm_stall_cycles", n, 2);
        check("wm_mask", last_mask, 16'hF000);
        idle();
        rd(32'h0000_200C, n);
        check("wm_read_misses", n, 4);
        idle();
        check("wm_read_dout", dout, 32'h5566_7788);

        // Conflict eviction on the same set.
        rd(32'h0000_0100, n);
        check("cf_first_hit", n, 0);
        rd(32'h0000_0500, n);
        check("cf_evict_miss", n, 4);
        idle();
        check("cf_evict_dout", dout, 32'h1000_0500);
        rd(32'h0000_0100, n);
        check("cf_reread_miss", n, 4);
        idle();
        check("cf_reread_dout", dout, 32'hDEAD_ABEF);

        // Reset while waiting for a refill; the response lands inside the reset window.
        resp_lat = 3;
        @(posedge clk);
        #1;
        addr = 32'h0000_3000; re = 1'b1; we = 4'b0000;
        hs0 = hs_count;
        n = 0;
        while (hs_count == hs0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_req_seen", hs_count - hs0, 1);
        @(posedge clk);
        #1;
        re = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rr_wait_stall", stall, 1'b1);
        check("rr_wait_noreq", mem_bus.mem_req_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        resp_lat = 2;
        @(negedge clk);
        check("rr_post_stall", stall, 1'b0);
        check("rr_post_dout", dout, 32'h0);
        rd(32'h0000_0100, n);
        check("rr_read_misses", n, 4);
        check("rr_req_addr", last_addr, 28'h10);
        idle();
        check("rr_read_dout", dout, 32'hDEAD_ABEF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
